// File: rtl/freq_sel_pkg.sv
// Shared constants and types for the frequency-selector plan scheduler.
// Error bit positions index the sticky err_flags vector.
package freq_sel_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int K_WIDTH    = 14;
   localparam int N_CH       = 128;
   localparam int IDX_WIDTH  = $clog2(N_CH);
   localparam int ERR_WIDTH  = 3;

   typedef logic [K_WIDTH-1:0]    k_t;
   typedef logic [IDX_WIDTH-1:0]  idx_t;
   typedef logic [IDX_WIDTH:0]    cnt_t;
   typedef logic [DATA_WIDTH-1:0] data_t;

   localparam int ERR_WR_PEND  = 0;
   localparam int ERR_CMT_PEND = 1;
   localparam int ERR_SKIP     = 2;

   // Entry counts above the plan depth are treated as a full plan.
   function automatic cnt_t clampNum(input cnt_t num);
      return (num > cnt_t'(N_CH)) ? cnt_t'(N_CH) : num;
   endfunction

endpackage

// File: rtl/plan_bank.sv
// Two-bank plan storage: software writes the shadow bank while the scheduler
// reads the active bank; flip_i swaps roles at a frame boundary.
module plan_bank
   import freq_sel_pkg::*;
(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               wrEn_i,
   input  logic [IDX_WIDTH-1:0] wrAddr_i,
   input  logic [K_WIDTH-1:0] wrData_i,
   input  logic               flip_i,
   input  logic [IDX_WIDTH-1:0] rdAddr_i,
   output logic [K_WIDTH-1:0] rdData_o
);

   k_t   bank0 [N_CH];
   k_t   bank1 [N_CH];
   logic sel_q;
   logic sel_d;

   // Reads follow the post-flip selection so a boundary beat sees the new plan.
   assign sel_d    = sel_q ^ flip_i;
   assign rdData_o = sel_d ? bank1[rdAddr_i] : bank0[rdAddr_i];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sel_q <= 1'b0;
      end else begin
         sel_q <= sel_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wrEn_i) begin
         if (sel_q) begin
            bank0[wrAddr_i] <= wrData_i;
         end else begin
            bank1[wrAddr_i] <= wrData_i;
         end
      end
   end

endmodule

// File: rtl/freq_plan_sched.sv
// Per-frame channel scheduler: compares each streamed beat against the active
// plan entry and forwards matches with channel index and last-channel flag.
module freq_plan_sched
   import freq_sel_pkg::*;
(
   input  logic                  dev_clk,
   input  logic                  reset,
   input  logic                  cfg_we,
   input  logic [IDX_WIDTH-1:0]  cfg_addr,
   input  logic [K_WIDTH-1:0]    cfg_k,
   input  logic [IDX_WIDTH:0]    cfg_num,
   input  logic                  cfg_commit,
   output logic                  swap_pending,
   output logic [IDX_WIDTH:0]    active_num,
   output logic [ERR_WIDTH-1:0]  err_flags,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [K_WIDTH-1:0]    k_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [IDX_WIDTH-1:0]  index_out,
   output logic                  last_out,
   output logic                  valid_out
);

   logic                 swapPending_q, swapPending_d;
   cnt_t                 pendNum_q, pendNum_d;
   cnt_t                 activeNum_q, activeNum_d;
   logic [ERR_WIDTH-1:0] err_q, err_d;
   cnt_t                 ptr_q, ptr_d;
   logic                 validOut_q, validOut_d;
   data_t                dataOut_q, dataOut_d;
   idx_t                 indexOut_q, indexOut_d;
   logic                 lastOut_q, lastOut_d;

   logic boundary;
   logic doSwap;
   cnt_t numEff;
   cnt_t ptrEff;
   idx_t rdAddr;
   k_t   planK;
   logic inPlan;
   logic hit;
   logic miss;
   logic wrEn;

   assign boundary = valid_in && (k_in == '0);
   assign doSwap   = boundary && swapPending_q;
   assign numEff   = doSwap ? pendNum_q : activeNum_q;
   assign ptrEff   = boundary ? '0 : ptr_q;
   assign rdAddr   = ptrEff[IDX_WIDTH-1:0];
   assign inPlan   = valid_in && (ptrEff < numEff);
   assign hit      = inPlan && (k_in == planK);
   assign miss     = inPlan && (k_in > planK);
   assign wrEn     = cfg_we && !swapPending_q && !reset;

   plan_bank u_bank (
      .clk_i    (dev_clk),
      .reset_i  (reset),
      .wrEn_i   (wrEn),
      .wrAddr_i (cfg_addr),
      .wrData_i (cfg_k),
      .flip_i   (doSwap),
      .rdAddr_i (rdAddr),
      .rdData_o (planK)
   );

   // Commit status is judged on the pre-swap pending flag, so a commit landing
   // on the swapping boundary beat is still rejected.
   always_comb begin
      swapPending_d = swapPending_q;
      pendNum_d     = pendNum_q;
      activeNum_d   = numEff;
      err_d         = err_q;
      ptr_d         = ptrEff;
      validOut_d    = hit;
      dataOut_d     = dataOut_q;
      indexOut_d    = indexOut_q;
      lastOut_d     = 1'b0;

      if (doSwap) begin
         swapPending_d = 1'b0;
      end
      if (cfg_we && swapPending_q) begin
         err_d[ERR_WR_PEND] = 1'b1;
      end
      if (cfg_commit) begin
         if (swapPending_q) begin
            err_d[ERR_CMT_PEND] = 1'b1;
         end else begin
            swapPending_d = 1'b1;
            pendNum_d     = clampNum(cfg_num);
         end
      end
      if (hit || miss) begin
         ptr_d = ptrEff + cnt_t'(1);
      end
      if (miss) begin
         err_d[ERR_SKIP] = 1'b1;
      end
      if (hit) begin
         dataOut_d  = data_in;
         indexOut_d = rdAddr;
         lastOut_d  = (ptrEff == numEff - cnt_t'(1));
      end
   end

   always_ff @(posedge dev_clk) begin
      if (reset) begin
         swapPending_q <= 1'b0;
         pendNum_q     <= '0;
         activeNum_q   <= '0;
         err_q         <= '0;
         ptr_q         <= '0;
         validOut_q    <= 1'b0;
         dataOut_q     <= '0;
         indexOut_q    <= '0;
         lastOut_q     <= 1'b0;
      end else begin
         swapPending_q <= swapPending_d;
         pendNum_q     <= pendNum_d;
         activeNum_q   <= activeNum_d;
         err_q         <= err_d;
         ptr_q         <= ptr_d;
         validOut_q    <= validOut_d;
         dataOut_q     <= dataOut_d;
         indexOut_q    <= indexOut_d;
         lastOut_q     <= lastOut_d;
      end
   end

   assign swap_pending = swapPending_q;
   assign active_num   = activeNum_q;
   assign err_flags    = err_q;
   assign data_out     = dataOut_q;
   assign index_out    = indexOut_q;
   assign last_out     = lastOut_q;
   assign valid_out    = validOut_q;

endmodule

// File: tb/tb_freq_plan_sched.sv
// Self-checking bench for freq_plan_sched: directed plan scenarios with literal
// expectations, then randomized plans/streams against a behavioural model.
module tb_freq_plan_sched;
   import freq_sel_pkg::*;

   logic                  dev_clk = 1'b0;
   logic                  reset;
   logic                  cfg_we;
   logic [IDX_WIDTH-1:0]  cfg_addr;
   logic [K_WIDTH-1:0]    cfg_k;
   logic [IDX_WIDTH:0]    cfg_num;
   logic                  cfg_commit;
   logic                  swap_pending;
   logic [IDX_WIDTH:0]    active_num;
   logic [2:0]            err_flags;
   logic [DATA_WIDTH-1:0] data_in;
   logic [K_WIDTH-1:0]    k_in;
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic [IDX_WIDTH-1:0]  index_out;
   logic                  last_out;
   logic                  valid_out;

   freq_plan_sched dut (
      .dev_clk      (dev_clk),
      .reset        (reset),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_k        (cfg_k),
      .cfg_num      (cfg_num),
      .cfg_commit   (cfg_commit),
      .swap_pending (swap_pending),
      .active_num   (active_num),
      .err_flags    (err_flags),
      .data_in      (data_in),
      .k_in         (k_in),
      .valid_in     (valid_in),
      .data_out     (data_out),
      .index_out    (index_out),
      .last_out     (last_out),
      .valid_out    (valid_out)
   );

   always #5 dev_clk = ~dev_clk;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;
   bit monEn = 1'b0;
   int gotQ[$];
   int expQ[$];

   // Behavioural model: plan banks as plain arrays, one beat evaluated per edge.
   int          bank [2][N_CH];
   int          mSel, mPending, mPendNum, mActive, mPtr;
   logic [2:0]  mErr;
   bit          expValid;
   logic [63:0] expData;
   int          expIdx;
   bit          expLast;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int enc(input int idx, input int data, input int last);
      return (idx << 20) | ((data & 16'hFFFF) << 1) | last;
   endfunction

   always @(posedge dev_clk) begin : model
      int oldPend;
      int e;
      expValid = 1'b0;
      if (reset) begin
         mSel = 0; mPending = 0; mPendNum = 0; mActive = 0; mPtr = 0; mErr = '0;
         expData = '0; expIdx = 0; expLast = 1'b0;
      end else begin
         oldPend = mPending;
         if (cfg_we) begin
            if (oldPend != 0) mErr[0] = 1'b1;
            else bank[1-mSel][cfg_addr] = int'(cfg_k);
         end
         if (valid_in) begin
            if (k_in == 0) begin
               mPtr = 0;
               if (oldPend != 0) begin
                  mSel = 1 - mSel;
                  mActive = mPendNum;
                  mPending = 0;
               end
            end
            if (mPtr < mActive) begin
               e = bank[mSel][mPtr];
               if (int'(k_in) == e) begin
                  expValid = 1'b1;
                  expData  = data_in;
                  expIdx   = mPtr;
                  expLast  = (mPtr == mActive - 1);
                  mPtr++;
               end else if (int'(k_in) > e) begin
                  mErr[2] = 1'b1;
                  mPtr++;
               end
            end
         end
         if (cfg_commit) begin
            if (oldPend != 0) mErr[1] = 1'b1;
            else begin
               mPending = 1;
               mPendNum = (int'(cfg_num) > N_CH) ? N_CH : int'(cfg_num);
            end
         end
      end
   end

   always @(negedge dev_clk) begin
      if (checkEn) begin
         checkOutput("valid_out", valid_out, expValid);
         checkOutput("swap_pending", swap_pending, mPending[0]);
         checkOutput("active_num", active_num, mActive);
         checkOutput("err_flags", err_flags, mErr);
         if (expValid) begin
            checkOutput("data_out", data_out, expData);
            checkOutput("index_out", index_out, expIdx);
            checkOutput("last_out", last_out, expLast);
         end
      end
      if (monEn && valid_out === 1'b1) begin
         gotQ.push_back(enc(int'(index_out), int'(data_out[15:0]), int'(last_out)));
      end
   end

   task automatic applyStimulus(input bit rst, input bit we, input int addr, input int kc,
                                input bit cmt, input int num, input logic [63:0] d,
                                input int k, input bit v);
      @(negedge dev_clk);
      reset      = rst;
      cfg_we     = we;
      cfg_addr   = idx_t'(addr);
      cfg_k      = k_t'(kc);
      cfg_commit = cmt;
      cfg_num    = cnt_t'(num);
      data_in    = d;
      k_in       = k_t'(k);
      valid_in   = v;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 64'd0, 0, 0);
   endtask

   task automatic cfgWrite(input int a, input int kc);
      applyStimulus(0, 1, a, kc, 0, 0, 64'd0, 0, 0);
   endtask

   task automatic commitPlan(input int n);
      applyStimulus(0, 0, 0, 0, 1, n, 64'd0, 0, 0);
   endtask

   task automatic beat(input int k, input logic [63:0] d);
      applyStimulus(0, 0, 0, 0, 0, 0, d, k, 1);
   endtask

   task automatic stdFrame(input int lastK);
      for (int k = 0; k <= lastK; k++) beat(k, 64'(k + 100));
   endtask

   task automatic checkQueue(input string name);
      checkOutput({name, "_count"}, gotQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         checkOutput(name, gotQ[i], expQ[i]);
      end
      gotQ.delete();
      expQ.delete();
   endtask

   initial begin
      reset = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_k = '0; cfg_num = '0; cfg_commit = 0;
      data_in = '0; k_in = '0; valid_in = 0;
      applyStimulus(1, 0, 0, 0, 0, 0, 64'd0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 64'd0, 0, 0);
      checkEn = 1'b1;
      checkOutput("reset_valid", valid_out, 0);
      checkOutput("reset_active", active_num, 0);
      checkOutput("reset_err", err_flags, 0);

      // Fill both banks with a known high value so no entry is ever undefined.
      for (int i = 0; i < N_CH; i++) cfgWrite(i, 16383);
      commitPlan(0);
      idle(1);
      beat(0, 64'd0);
      for (int i = 0; i < N_CH; i++) cfgWrite(i, 16383);
      applyStimulus(1, 0, 0, 0, 0, 0, 64'd0, 0, 0);
      idle(1);

      // Plan {3,5,9}: two identical frames.
      monEn = 1'b1;
      cfgWrite(0, 3); cfgWrite(1, 5); cfgWrite(2, 9);
      commitPlan(3);
      idle(1);
      checkOutput("pend_after_commit", swap_pending, 1);
      beat(0, 64'd100);
      beat(1, 64'd101);
      checkOutput("pend_after_swap", swap_pending, 0);
      checkOutput("active_after_swap", active_num, 3);
      for (int k = 2; k <= 15; k++) beat(k, 64'(k + 100));
      idle(3);
      expQ = '{enc(0, 103, 0), enc(1, 105, 0), enc(2, 109, 1)};
      checkQueue("frame1");
      stdFrame(15);
      idle(3);
      expQ = '{enc(0, 103, 0), enc(1, 105, 0), enc(2, 109, 1)};
      checkQueue("frame2");

      // Mid-frame commit of {4}: takes effect only at the next boundary.
      for (int k = 0; k <= 6; k++) beat(k, 64'(k + 100));
      applyStimulus(0, 1, 0, 4, 1, 1, 64'd107, 7, 1);
      for (int k = 8; k <= 15; k++) beat(k, 64'(k + 100));
      idle(3);
      checkOutput("pend_mid_frame", swap_pending, 1);
      expQ = '{enc(0, 103, 0), enc(1, 105, 0), enc(2, 109, 1)};
      checkQueue("frame3");
      stdFrame(15);
      idle(3);
      checkOutput("active_one", active_num, 1);
      expQ = '{enc(0, 104, 1)};
      checkQueue("frame4");

      // Plan {3,5} with k=3 skipped.
      cfgWrite(0, 3); cfgWrite(1, 5);
      commitPlan(2);
      beat(0, 64'd100); beat(1, 64'd101); beat(2, 64'd102);
      for (int k = 4; k <= 15; k++) beat(k, 64'(k + 100));
      idle(3);
      checkOutput("err_skip", err_flags, 3'b100);
      expQ = '{enc(1, 105, 1)};
      checkQueue("frame5");

      // Writes/commits while pending, oversize cfg_num.
      applyStimulus(1, 0, 0, 0, 0, 0, 64'd0, 0, 0);
      idle(1);
      cfgWrite(0, 7);
      commitPlan(200);
      cfgWrite(0, 50);
      commitPlan(5);
      idle(1);
      checkOutput("err_pending", err_flags, 3'b011);
      checkOutput("pend_held", swap_pending, 1);
      beat(0, 64'd100);
      beat(1, 64'd101);
      checkOutput("active_clamped", active_num, 128);
      for (int k = 2; k <= 10; k++) beat(k, 64'(k + 100));
      idle(3);
      expQ = '{enc(0, 107, 0), enc(2, 109, 0)};
      checkQueue("frame6");
      checkOutput("err_all", err_flags, 3'b111);

      // Reset landing on a matching beat.
      for (int k = 0; k <= 6; k++) beat(k, 64'(k + 100));
      applyStimulus(1, 0, 0, 0, 0, 0, 64'd107, 7, 1);
      idle(1);
      checkOutput("rst_valid", valid_out, 0);
      checkOutput("rst_data", data_out, 0);
      checkOutput("rst_index", index_out, 0);
      checkOutput("rst_last", last_out, 0);
      checkOutput("rst_active", active_num, 0);
      checkOutput("rst_err", err_flags, 0);
      gotQ.delete();
      stdFrame(15);
      idle(3);
      checkQueue("post_rst_empty");
      commitPlan(1);
      stdFrame(15);
      idle(3);
      expQ = '{enc(0, 107, 1)};
      checkQueue("post_rst_commit");
      monEn = 1'b0;

      // Randomized plans and streams, checked every cycle against the model.
      for (int f = 0; f < 30; f++) begin
         int n, v, k;
         if ($urandom_range(0, 7) == 0) applyStimulus(1, 0, 0, 0, 0, 0, 64'd0, 0, 0);
         if ($urandom_range(0, 1) == 1) begin
            n = $urandom_range(1, 40);
            v = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
               cfgWrite(i, v);
               v += $urandom_range(1, 4);
            end
            commitPlan(($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : n);
         end
         k = 0;
         while (k <= 200) begin
            if ($urandom_range(0, 4) == 0) begin
               applyStimulus(0, 0, 0, 0, 0, 0, {$urandom, $urandom}, $urandom_range(0, 300), 0);
            end else begin
               applyStimulus(0, ($urandom_range(0, 49) == 0), $urandom_range(0, 127),
                             $urandom_range(0, 300), ($urandom_range(0, 49) == 0),
                             $urandom_range(0, 60), {$urandom, $urandom}, k, 1);
               k += $urandom_range(0, 3);
            end
         end
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_plan_sched.md
Name: freq_plan_sched

Overview:
Double-buffered plan table and per-frame scheduler for the frequency-selector datapath. Software loads an ascending list of up to 128 bin indices (k) into a shadow bank, then commits it. The active plan swaps in on the next frame boundary. Each streamed (data, k) beat is compared against the current plan entry; matches are forwarded with their channel index and a last-channel flag, ready for AXI-Stream packing downstream.

Parameters:
DATA_WIDTH, 64, width of streamed sample word
K_WIDTH, 14, width of bin index k
N_CH, 128, plan depth (max selected channels)
IDX_WIDTH, 7, clog2(N_CH), channel index width

Ports:
dev_clk  in  1  datapath clock; sole clock
reset  in  1  synchronous, active-high
cfg_we  in  1  write shadow entry cfg_addr with cfg_k
cfg_addr  in  IDX_WIDTH  shadow entry address
cfg_k  in  K_WIDTH  plan value
cfg_num  in  IDX_WIDTH+1  entry count, sampled on cfg_commit
cfg_commit  in  1  single-cycle request to swap banks at next frame boundary
swap_pending  out  1  commit accepted, swap not yet done
active_num  out  IDX_WIDTH+1  entry count of active plan
err_flags  out  3  sticky: [0] write while pending, [1] commit while pending, [2] skipped entry
data_in  in  DATA_WIDTH  sample
k_in  in  K_WIDTH  bin index of sample
valid_in  in  1  beat qualifier; no backpressure
data_out  out  DATA_WIDTH  selected sample
index_out  out  IDX_WIDTH  channel number (plan position)
last_out  out  1  high with valid_out when index_out == active_num-1
valid_out  out  1  selected beat

Behaviour:
- Reset (sync, high):
  - all outputs 0; active_num=0, swap_pending=0, err_flags=0, ptr=0, active bank select=0.
  - Bank contents are not cleared.
  - A reset mid-frame drops any in-flight beat; valid_out is 0 on the cycle after reset deasserts.
- Storage and writes:
  - Two banks of N_CH x K_WIDTH.
  - cfg_we writes only the shadow bank. If cfg_we arrives while swap_pending=1, the write is discarded and err_flags[0] is set.
- Commit:
  - cfg_commit with swap_pending=0: latch min(cfg_num,N_CH) into pending_num and set swap_pending.
  - cfg_commit with swap_pending=1: ignored, err_flags[1] set.
  - cfg_we and cfg_commit in the same cycle: the write lands first, then the commit.
- Frame boundary: valid_in && k_in==0. On that beat:
  - if swap_pending, flip bank select, set active_num=pending_num and clear swap_pending;
  - ptr is forced to 0;
  - the beat is evaluated against the new plan entry 0.
- Scheduler, per valid_in beat with effective ptr p (0 on a boundary):
  - if p >= active_num: no action.
  - else if k_in == plan[p]: next cycle valid_out=1, data_out=data_in, index_out=p, last_out=(p==active_num-1); ptr=p+1.
  - else if k_in > plan[p]: entry missed; err_flags[2] set, ptr=p+1, no output this beat (no multi-skip).
  - else (k_in < plan[p]): no action.
- Timing:
  - Latency is exactly 1 cycle, valid_in to valid_out; throughput 1 beat/cycle.
  - valid_in=0 leaves all state unchanged; valid_out is 0 on the following cycle.
- Arithmetic:
  - Comparisons are unsigned.
  - ptr is IDX_WIDTH+1 bits and saturates at active_num; no wrap.
  - active_num=0 produces no output.
- Plans must be strictly ascending. Duplicate entries give at most one match per beat; the second entry then matches only a later beat with equal k.
- Error flags clear only on reset.

Decomposition:
- Package freq_sel_pkg:
  - constants K_WIDTH, IDX_WIDTH, N_CH, DATA_WIDTH;
  - typedefs k_t, idx_t, cnt_t (IDX_WIDTH+1);
  - err bit positions ERR_WR_PEND, ERR_CMT_PEND, ERR_SKIP.
- Sub-module plan_bank:
  - two-bank distributed RAM;
  - one sync write port to the shadow bank;
  - one async read port on the active bank at ptr;
  - bank-select flip input.
- The top level holds the commit logic, ptr, compare and output registers.

Test Plan:
- Load plan {3,5,9}, cfg_num=3, commit; stream k=0..15 with data=k+100 -> swap on k=0. Outputs (idx,data,last) = (0,103,0) at k=3+1cy, (1,105,0), (2,109,1); swap_pending 1→0 at that k=0 beat.
- Second frame k=0..15 with data=k+100 -> identical three outputs, ptr restarted at 0.
- Commit a new plan {4} mid-frame (after k=6) -> rest of frame still uses {3,5,9} (match at k=9). Next frame yields only (0,104,1).
- Plan {3,5}; stream skips k=3 (0,1,2,4,5...) -> err_flags[2]=1, no output at k=4. At k=5, plan[1]=5 matches: output (1,105,1).
- cfg_we while swap_pending, and a second cfg_commit while pending -> err_flags=3'b011, shadow entry unchanged on readback after swap. cfg_num=200 -> active_num=128.
- Assert reset during a frame with matches in flight -> next cycle all outputs 0, active_num=0. Streaming after reset produces no output until a new commit plus a k=0 boundary.
